// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module : systolic_skew_feeder
// Turns per-beat A columns / B rows into skewed wavefronts for a systolic array.
// Rev    : 1.0  initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_ROWS   = 16,
    parameter int  NUM_COLS   = 16,
    parameter int  MAX_K      = 256,
    localparam int KW         = $clog2(MAX_K + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [KW-1:0]                        k_len_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  a_col_i,
    input  logic [NUM_COLS-1:0][DATA_WIDTH-1:0]  b_row_i,
    output logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  sa_input_o,
    output logic [NUM_ROWS-1:0]                  sa_input_valid_o,
    output logic [NUM_COLS-1:0][DATA_WIDTH-1:0]  sa_weight_o,
    output logic [NUM_COLS-1:0]                  sa_weight_valid_o,
    output logic                                 acc_clear_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int              c_drain_len  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
    localparam int              c_dcw        = $clog2(c_drain_len + 1);
    localparam logic [KW-1:0]   c_max_k      = KW'(MAX_K);
    localparam logic [c_dcw-1:0] c_drain_last = c_dcw'(c_drain_len - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_beat_cnt;
    logic [c_dcw-1:0] r_drain_cnt;
    logic [KW-1:0]    w_beat_next;
    logic             w_live;
    logic             w_start_ok;
    logic             w_accept;

    // Every control output is forced low while rst_i is held, not just after the edge.
    assign w_live      = ~rst_i;
    assign w_start_ok  = w_live && (r_state == S_IDLE) && start_i &&
                         (k_len_i != '0) && (k_len_i <= c_max_k);
    assign in_ready_o  = w_live && (r_state == S_FEED);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_beat_next = r_beat_cnt + 1'b1;

    assign acc_clear_o = w_start_ok;
    assign busy_o      = w_live && (r_state != S_IDLE);
    assign done_o      = w_live && (r_state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_k        <= k_len_i;
                        r_beat_cnt <= '0;
                        r_state    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_beat_next;
                        if (w_beat_next == r_k) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Longest lane is c_drain_len deep, so this flushes every lane.
                    if (r_drain_cnt == c_drain_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Lane n is n+1 registers deep; non-accepted cycles shift in zero bubbles.
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        logic [DATA_WIDTH-1:0] r_data [0:i];
        logic                  r_vld  [0:i];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int s = 0; s <= i; s++) begin
                    r_data[s] <= '0;
                    r_vld[s]  <= 1'b0;
                end
            end else begin
                r_data[0] <= w_accept ? a_col_i[i] : '0;
                r_vld[0]  <= w_accept;
                for (int s = 1; s <= i; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

        assign sa_input_o[i]       = w_live ? r_data[i] : '0;
        assign sa_input_valid_o[i] = w_live && r_vld[i];
    end

    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
        logic [DATA_WIDTH-1:0] r_data [0:j];
        logic                  r_vld  [0:j];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int s = 0; s <= j; s++) begin
                    r_data[s] <= '0;
                    r_vld[s]  <= 1'b0;
                end
            end else begin
                r_data[0] <= w_accept ? b_row_i[j] : '0;
                r_vld[0]  <= w_accept;
                for (int s = 1; s <= j; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

        assign sa_weight_o[j]       = w_live ? r_data[j] : '0;
        assign sa_weight_valid_o[j] = w_live && r_vld[j];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_skew_feeder
// Scoreboard bench: expected lane beats are queued per lane when driven.
// Rev    : 1.0  initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int NR = 4;
    localparam int NC = 3;
    localparam int DW = 32;
    localparam int MK = 6;
    localparam int KW = $clog2(MK + 1);
    localparam int M  = 4;
    localparam int NL = NR + NC;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   start_i = 1'b0;
    logic [KW-1:0]          k_len_i = '0;
    logic                   in_valid_i = 1'b0;
    logic                   in_ready_o;
    logic [NR-1:0][DW-1:0]  a_col_i = '0;
    logic [NC-1:0][DW-1:0]  b_row_i = '0;
    logic [NR-1:0][DW-1:0]  sa_input_o;
    logic [NR-1:0]          sa_input_valid_o;
    logic [NC-1:0][DW-1:0]  sa_weight_o;
    logic [NC-1:0]          sa_weight_valid_o;
    logic                   acc_clear_o;
    logic                   busy_o;
    logic                   done_o;

    systolic_skew_feeder #(
        .DATA_WIDTH (DW),
        .NUM_ROWS   (NR),
        .NUM_COLS   (NC),
        .MAX_K      (MK)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .k_len_i           (k_len_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .a_col_i           (a_col_i),
        .b_row_i           (b_row_i),
        .sa_input_o        (sa_input_o),
        .sa_input_valid_o  (sa_input_valid_o),
        .sa_weight_o       (sa_weight_o),
        .sa_weight_valid_o (sa_weight_valid_o),
        .acc_clear_o       (acc_clear_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    exp_t          sb [NL][$];
    int            vcount [NL];
    int            first_cyc [NL];
    logic [DW-1:0] first_dat [NL];
    int            dcount = 0;
    int            ccount = 0;
    int            s_v [NL];
    int            s_d;
    int            s_c;

    logic          mvv [NL];
    logic [DW-1:0] mdd [NL];
    exp_t          me;

    logic [DW-1:0] c_a [NR] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [DW-1:0] c_b [NC] = '{32'h4120_0000, 32'h4130_0000, 32'h4140_0000};

    initial begin
        for (int l = 0; l < NL; l++) begin
            vcount[l]    = 0;
            first_cyc[l] = -1;
            first_dat[l] = '0;
        end
    end

    // Lane monitor: pops the scoreboard on every valid, flags late/missing beats and dirty bubbles.
    always @(negedge clk) begin
        for (int l = 0; l < NR; l++) begin
            mvv[l] = sa_input_valid_o[l];
            mdd[l] = sa_input_o[l];
        end
        for (int j = 0; j < NC; j++) begin
            mvv[NR+j] = sa_weight_valid_o[j];
            mdd[NR+j] = sa_weight_o[j];
        end
        if (done_o)      dcount++;
        if (acc_clear_o) ccount++;
        for (int l = 0; l < NL; l++) begin
            if (mvv[l] === 1'b1) begin
                vcount[l]++;
                if (first_cyc[l] < 0) begin
                    first_cyc[l] = cyc;
                    first_dat[l] = mdd[l];
                end
                total++;
                if (sb[l].size() == 0) begin
                    bad++;
                    $display("FAIL lane%0d_extra: cyc=%0d got=%h required=no beat", l, cyc, mdd[l]);
                end else begin
                    me = sb[l].pop_front();
                    if (me.cyc != cyc || me.data !== mdd[l]) begin
                        bad++;
                        $display("FAIL lane%0d_beat: got cyc=%0d data=%h required cyc=%0d data=%h",
                                 l, cyc, mdd[l], me.cyc, me.data);
                    end
                end
            end else begin
                if (sb[l].size() != 0 && sb[l][0].cyc <= cyc) begin
                    total++;
                    bad++;
                    me = sb[l].pop_front();
                    $display("FAIL lane%0d_missing: cyc=%0d valid=%b required data=%h at cyc=%0d",
                             l, cyc, mvv[l], me.data, me.cyc);
                end
                total++;
                if (mdd[l] !== '0) begin
                    bad++;
                    $display("FAIL lane%0d_bubble: cyc=%0d got=%h required=0", l, cyc, mdd[l]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            start_i    = 1'b0;
            in_valid_i = 1'b0;
        end
    endtask

    task automatic snap();
        for (int l = 0; l < NL; l++) s_v[l] = vcount[l];
        s_d = dcount;
        s_c = ccount;
    endtask

    task automatic start_tile(input int k, output int t0);
        step();
        start_i    = 1'b1;
        k_len_i    = k[KW-1:0];
        in_valid_i = 1'b0;
        t0         = cyc;
        @(negedge clk);
    endtask

    task automatic drive_beats(input int k, input logic [7:0] pat, input int plen,
                               input logic use_const, output int last, output int rdy_miss);
        int   n;
        int   idx;
        exp_t e;
        n = 0; idx = 0; last = -1; rdy_miss = 0;
        while (n < k && idx < 64) begin
            step();
            start_i    = 1'b0;
            in_valid_i = (idx < plen) ? pat[idx] : 1'b1;
            for (int i = 0; i < NR; i++) a_col_i[i] = use_const ? c_a[i] : DW'($urandom());
            for (int j = 0; j < NC; j++) b_row_i[j] = use_const ? c_b[j] : DW'($urandom());
            if (in_valid_i) begin
                for (int i = 0; i < NR; i++) begin
                    e.cyc = cyc + i + 1; e.data = a_col_i[i]; sb[i].push_back(e);
                end
                for (int j = 0; j < NC; j++) begin
                    e.cyc = cyc + j + 1; e.data = b_row_i[j]; sb[NR+j].push_back(e);
                end
                n++;
                last = cyc;
            end
            idx++;
            @(negedge clk);
            if (in_ready_o !== 1'b1 || busy_o !== 1'b1) rdy_miss++;
        end
        if (n < k) begin
            bad++;
            $display("FAIL feed_budget: beats=%0d required=%0d", n, k);
        end
    endtask

    task automatic finish_tile(input logic hold_valid, input int start_at,
                               output int done_cyc, output int rdy_seen);
        done_cyc = -1;
        rdy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            in_valid_i = hold_valid;
            start_i    = (c == start_at);
            k_len_i    = KW'(2);
            for (int i = 0; i < NR; i++) a_col_i[i] = DW'($urandom());
            for (int j = 0; j < NC; j++) b_row_i[j] = DW'($urandom());
            @(negedge clk);
            if (in_ready_o === 1'b1) rdy_seen++;
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic check_tail(input string name, input int nbeats, input int ndone, input int nclr);
        int bad_lane;
        bad_lane = -1;
        for (int l = 0; l < NL; l++)
            if (vcount[l] - s_v[l] != nbeats && bad_lane < 0) bad_lane = l;
        total++;
        if (bad_lane >= 0) begin
            bad++;
            $display("FAIL %s_vcount: lane%0d got=%0d required=%0d", name, bad_lane,
                     vcount[bad_lane] - s_v[bad_lane], nbeats);
        end
        total++;
        if (dcount - s_d != ndone || ccount - s_c != nclr) begin
            bad++;
            $display("FAIL %s_pulses: done=%0d clear=%0d required done=%0d clear=%0d", name,
                     dcount - s_d, ccount - s_c, ndone, nclr);
        end
        for (int l = 0; l < NL; l++) begin
            total++;
            if (sb[l].size() != 0) begin
                bad++;
                $display("FAIL %s_pending: lane%0d left=%0d required=0", name, l, sb[l].size());
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; k_len_i = KW'(2); in_valid_i = 1'b1;
        step(); step();
        @(negedge clk);
        total++;
        if ({in_ready_o, acc_clear_o, busy_o, done_o} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got=%b required=0000", {in_ready_o, acc_clear_o, busy_o, done_o});
        end
        total++;
        if (sa_input_valid_o !== '0 || sa_weight_valid_o !== '0 || sa_input_o !== '0 || sa_weight_o !== '0) begin
            bad++;
            $display("FAIL reset_lanes: vin=%b vwt=%b required all zero", sa_input_valid_o, sa_weight_valid_o);
        end
        step();
        rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready_o, busy_o, done_o} !== 3'b0 || sa_input_valid_o !== '0) begin
            bad++;
            $display("FAIL after_reset: got=%b required=000", {in_ready_o, busy_o, done_o});
        end
        idle(2);
    endtask

    task automatic test_basic();
        int t0, last, rm, dc, rs;
        idle(1);
        for (int l = 0; l < NL; l++) first_cyc[l] = -1;
        snap();
        start_tile(4, t0);
        total++;
        if (acc_clear_o !== 1'b1 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_start: clr=%b busy=%b rdy=%b required 1 0 0", acc_clear_o, busy_o, in_ready_o);
        end
        drive_beats(4, 8'hFF, 8, 1'b1, last, rm);
        total++;
        if (last != t0 + 4 || rm != 0) begin
            bad++;
            $display("FAIL basic_feed: last=%0d rdy_miss=%0d required last=%0d miss=0", last, rm, t0 + 4);
        end
        finish_tile(1'b1, -1, dc, rs);
        total++;
        if (dc != t0 + 9 || rs != 0) begin
            bad++;
            $display("FAIL basic_done: cyc=%0d rdy_in_drain=%0d required cyc=%0d rdy=0", dc, rs, t0 + 9);
        end
        idle(3);
        total++;
        if (first_cyc[3] != t0 + 5 || first_dat[3] !== 32'h4080_0000) begin
            bad++;
            $display("FAIL basic_in3_first: cyc=%0d data=%h required cyc=%0d data=40800000",
                     first_cyc[3], first_dat[3], t0 + 5);
        end
        total++;
        if (first_cyc[NR+2] != t0 + 4 || first_dat[NR+2] !== 32'h4140_0000) begin
            bad++;
            $display("FAIL basic_wt2_first: cyc=%0d data=%h required cyc=%0d data=41400000",
                     first_cyc[NR+2], first_dat[NR+2], t0 + 4);
        end
        check_tail("basic", 4, 1, 1);
    endtask

    task automatic test_bubble();
        int t0, last, rm, dc, rs;
        idle(1);
        for (int l = 0; l < NL; l++) first_cyc[l] = -1;
        snap();
        start_tile(3, t0);
        drive_beats(3, 8'b0000_1101, 4, 1'b0, last, rm);
        total++;
        if (last != t0 + 4 || rm != 0) begin
            bad++;
            $display("FAIL bubble_feed: last=%0d miss=%0d required last=%0d miss=0", last, rm, t0 + 4);
        end
        finish_tile(1'b0, -1, dc, rs);
        total++;
        if (dc != last + M + 1) begin
            bad++;
            $display("FAIL bubble_done: cyc=%0d required=%0d", dc, last + M + 1);
        end
        idle(3);
        total++;
        if (first_cyc[0] != t0 + 2) begin
            bad++;
            $display("FAIL bubble_in0_first: cyc=%0d required=%0d", first_cyc[0], t0 + 2);
        end
        check_tail("bubble", 3, 1, 1);
    endtask

    task automatic test_bad_k();
        int t0, last, rm, dc, rs;
        idle(1);
        snap();
        step();
        start_i = 1'b1; k_len_i = KW'(0);
        @(negedge clk);
        total++;
        if (acc_clear_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL k0_start: clr=%b busy=%b required 0 0", acc_clear_o, busy_o);
        end
        step();
        k_len_i = KW'(MK + 1);
        @(negedge clk);
        total++;
        if (acc_clear_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL kmax_plus1_start: clr=%b busy=%b rdy=%b required 0 0 0", acc_clear_o, busy_o, in_ready_o);
        end
        step();
        start_i = 1'b0;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL badk_idle: busy=%b rdy=%b required 0 0", busy_o, in_ready_o);
        end
        start_tile(1, t0);
        drive_beats(1, 8'hFF, 8, 1'b0, last, rm);
        finish_tile(1'b0, -1, dc, rs);
        total++;
        if (last != t0 + 1 || dc != last + 5) begin
            bad++;
            $display("FAIL k1_done: last=%0d done=%0d required last=%0d done=%0d", last, dc, t0 + 1, t0 + 6);
        end
        idle(3);
        check_tail("badk", 1, 1, 1);
    endtask

    task automatic test_reset_mid();
        int t0, last, rm, dc, rs;
        idle(1);
        snap();
        start_tile(4, t0);
        drive_beats(2, 8'hFF, 8, 1'b0, last, rm);
        step();
        rst_i = 1'b1; in_valid_i = 1'b1;
        for (int l = 0; l < NL; l++) sb[l].delete();
        @(negedge clk);
        step();
        rst_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready_o, acc_clear_o, busy_o, done_o} !== 4'b0) begin
            bad++;
            $display("FAIL midrst_ctrl: got=%b required=0000", {in_ready_o, acc_clear_o, busy_o, done_o});
        end
        total++;
        if (sa_input_valid_o !== '0 || sa_weight_valid_o !== '0 || sa_input_o !== '0 || sa_weight_o !== '0) begin
            bad++;
            $display("FAIL midrst_lanes: vin=%b vwt=%b required all zero", sa_input_valid_o, sa_weight_valid_o);
        end
        idle(8);
        total++;
        if (dcount != s_d) begin
            bad++;
            $display("FAIL midrst_nodone: done pulses=%0d required=0", dcount - s_d);
        end
        snap();
        start_tile(2, t0);
        drive_beats(2, 8'hFF, 8, 1'b0, last, rm);
        finish_tile(1'b0, -1, dc, rs);
        total++;
        if (dc != last + M + 1) begin
            bad++;
            $display("FAIL midrst_fresh_done: cyc=%0d required=%0d", dc, last + M + 1);
        end
        idle(3);
        check_tail("midrst", 2, 1, 1);
    endtask

    task automatic test_back_to_back();
        int t0, t1, last, last2, rm, dc, dc2, rs;
        idle(1);
        snap();
        start_tile(3, t0);
        drive_beats(3, 8'hFF, 8, 1'b0, last, rm);
        finish_tile(1'b1, 1, dc, rs);
        total++;
        if (dc != last + M + 1 || rs != 0) begin
            bad++;
            $display("FAIL b2b_first_done: cyc=%0d rdy=%0d required cyc=%0d rdy=0", dc, rs, last + M + 1);
        end
        start_tile(MK, t1);
        total++;
        if (t1 != dc + 1 || acc_clear_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: cyc=%0d clr=%b required cyc=%0d clr=1", t1, acc_clear_o, dc + 1);
        end
        drive_beats(MK, 8'b0101_1011, 8, 1'b0, last2, rm);
        finish_tile(1'b0, -1, dc2, rs);
        total++;
        if (dc2 != last2 + M + 1 || rm != 0) begin
            bad++;
            $display("FAIL b2b_second_done: cyc=%0d miss=%0d required cyc=%0d miss=0", dc2, rm, last2 + M + 1);
        end
        idle(3);
        check_tail("b2b", 3 + MK, 2, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_bad_k();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
